// File: rtl/text_console_ctrl.sv
// Character-cell console sequencer: takes CPU character commands, keeps the cursor,
// and drives the text/colour memory ports, including autonomous clear and scroll-up.
// Latency: printable char written 1 cycle after accept, ready again the cycle after.
// Backpressure: cmd_ready is high only in IDLE; clear/scroll hold off the CPU.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake; cmd_char/cmd_color payload
//   mem_we/mem_waddr/mem_wchar/mem_wcolor   shared write port of text+colour memories
//   mem_raddr -> mem_rchar/mem_rcolor       read port, data one cycle after address
//   cursor_col, cursor_row          current cursor cell
//   busy                            high whenever the controller is not IDLE
module text_console_ctrl #(
  parameter int         COLS        = 79,
  parameter int         ROWS        = 12,
  parameter logic [7:0] BLANK_CHAR  = 8'h20,
  parameter logic [7:0] BLANK_COLOR = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_char,
  input  logic [7:0] cmd_color,
  output logic       mem_we,
  output logic [9:0] mem_waddr,
  output logic [7:0] mem_wchar,
  output logic [7:0] mem_wcolor,
  output logic [9:0] mem_raddr,
  input  logic [7:0] mem_rchar,
  input  logic [7:0] mem_rcolor,
  output logic [6:0] cursor_col,
  output logic [3:0] cursor_row,
  output logic       busy
);

  localparam logic [9:0] COLS_W      = 10'(COLS);
  localparam logic [9:0] LAST_CELL   = 10'(COLS * ROWS - 1);
  // last destination cell of the row-copy phase; the blanking phase follows on
  localparam logic [9:0] SCROLL_LAST = 10'(COLS * (ROWS - 1) - 1);
  localparam logic [6:0] LAST_COL    = 7'(COLS - 1);
  localparam logic [3:0] LAST_ROW    = 4'(ROWS - 1);

  typedef enum logic [2:0] {
    INIT, CLEAR, IDLE, WRITE, SCROLL_RD, SCROLL_WR, SCROLL_CLR
  } state_t;

  state_t     state_q;
  logic [9:0] idx_q;
  logic [6:0] col_q;
  logic [3:0] row_q;
  logic [9:0] waddr_q;
  logic [7:0] wchar_q;
  logic [7:0] wcolor_q;
  logic       bs_q;      // pending WRITE came from a backspace: cursor must not advance
  logic [9:0] raddr_q;   // keeps mem_raddr stable outside SCROLL_RD

  logic [9:0] cur_addr;
  logic       printable;

  assign cur_addr  = 10'(row_q) * COLS_W + 10'(col_q);
  assign printable = (cmd_char >= 8'h20) && (cmd_char <= 8'h7E);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT;
      idx_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      waddr_q  <= '0;
      wchar_q  <= '0;
      wcolor_q <= '0;
      bs_q     <= 1'b0;
      raddr_q  <= '0;
    end else begin
      case (state_q)
        INIT: begin
          idx_q   <= '0;
          state_q <= CLEAR;
        end

        CLEAR: begin
          if (idx_q == LAST_CELL) begin
            idx_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + 10'd1;
          end
        end

        IDLE: begin
          if (cmd_valid) begin
            if (printable) begin
              waddr_q  <= cur_addr;
              wchar_q  <= cmd_char;
              wcolor_q <= cmd_color;
              bs_q     <= 1'b0;
              state_q  <= WRITE;
            end else begin
              case (cmd_char)
                8'h0A: begin
                  col_q <= '0;
                  if (row_q == LAST_ROW) begin
                    idx_q   <= '0;
                    state_q <= SCROLL_RD;
                  end else begin
                    row_q <= row_q + 4'd1;
                  end
                end
                8'h08: begin
                  if (col_q != 7'd0) begin
                    col_q    <= col_q - 7'd1;
                    waddr_q  <= cur_addr - 10'd1;  // same row, one cell left
                    wchar_q  <= BLANK_CHAR;
                    wcolor_q <= BLANK_COLOR;
                    bs_q     <= 1'b1;
                    state_q  <= WRITE;
                  end
                end
                8'h0C: begin
                  idx_q   <= '0;
                  state_q <= CLEAR;
                end
                default: begin
                end
              endcase
            end
          end
        end

        WRITE: begin
          state_q <= IDLE;
          if (!bs_q) begin
            if (col_q == LAST_COL) begin
              col_q <= '0;
              if (row_q == LAST_ROW) begin
                idx_q   <= '0;
                state_q <= SCROLL_RD;
              end else begin
                row_q <= row_q + 4'd1;
              end
            end else begin
              col_q <= col_q + 7'd1;
            end
          end
        end

        SCROLL_RD: begin
          raddr_q <= idx_q + COLS_W;
          state_q <= SCROLL_WR;
        end

        SCROLL_WR: begin
          // idx simply continues into the bottom-row blanking range
          idx_q   <= idx_q + 10'd1;
          state_q <= (idx_q == SCROLL_LAST) ? SCROLL_CLR : SCROLL_RD;
        end

        SCROLL_CLR: begin
          if (idx_q == LAST_CELL) begin
            idx_q   <= '0;
            col_q   <= '0;
            row_q   <= LAST_ROW;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + 10'd1;
          end
        end

        default: state_q <= INIT;
      endcase
    end
  end

  // Outputs depend on registered state only; the one exception is the scroll
  // copy data, which passes straight from the read port to the write port.
  always_comb begin
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wchar  = '0;
    mem_wcolor = '0;
    case (state_q)
      CLEAR, SCROLL_CLR: begin
        mem_we     = 1'b1;
        mem_waddr  = idx_q;
        mem_wchar  = BLANK_CHAR;
        mem_wcolor = BLANK_COLOR;
      end
      WRITE: begin
        mem_we     = 1'b1;
        mem_waddr  = waddr_q;
        mem_wchar  = wchar_q;
        mem_wcolor = wcolor_q;
      end
      SCROLL_WR: begin
        mem_we     = 1'b1;
        mem_waddr  = idx_q;
        mem_wchar  = mem_rchar;
        mem_wcolor = mem_rcolor;
      end
      default: begin
      end
    endcase
  end

  assign mem_raddr  = (state_q == SCROLL_RD) ? (idx_q + COLS_W) : raddr_q;
  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Testbench for text_console_ctrl: scoreboard of expected memory writes plus a
// behavioural screen model and a one-cycle-latency memory behind the read port.
// All sampling happens 1 time unit after the rising edge.
module tb_text_console_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_char = 8'h00;
  logic [7:0] cmd_color = 8'h00;
  logic       mem_we;
  logic [9:0] mem_waddr;
  logic [7:0] mem_wchar;
  logic [7:0] mem_wcolor;
  logic [9:0] mem_raddr;
  logic [7:0] mem_rchar;
  logic [7:0] mem_rcolor;
  logic [6:0] cursor_col;
  logic [3:0] cursor_row;
  logic       busy;

  text_console_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_char(cmd_char), .cmd_color(cmd_color),
    .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wchar(mem_wchar), .mem_wcolor(mem_wcolor),
    .mem_raddr(mem_raddr), .mem_rchar(mem_rchar), .mem_rcolor(mem_rcolor),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 clk = ~clk;

  // memory environment: text and colour RAMs with registered read
  logic [7:0] mchar [0:1023];
  logic [7:0] mcol  [0:1023];
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mchar[mem_waddr] <= mem_wchar;
      mcol[mem_waddr]  <= mem_wcolor;
    end
    mem_rchar  <= mchar[mem_raddr];
    mem_rcolor <= mcol[mem_raddr];
  end

  typedef struct {
    logic [9:0] a;
    logic [7:0] c;
    logic [7:0] k;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] scr_c [0:947];
  logic [7:0] scr_k [0:947];
  int         exp_col = 0;
  int         exp_row = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_count = 0;
  int last_we_cyc = 0;
  int prev_we_cyc = 0;
  logic [9:0] last_waddr = '0;

  // ---------------- reference model ----------------
  task automatic push_wr(input int a, input logic [7:0] c, input logic [7:0] k);
    wr_t e;
    e.a = 10'(a);
    e.c = c;
    e.k = k;
    scr_c[a] = c;
    scr_k[a] = k;
    exp_q.push_back(e);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 948; i++) push_wr(i, 8'h20, 8'h00);
    exp_col = 0;
    exp_row = 0;
  endtask

  task automatic model_scroll();
    for (int i = 0; i < 869; i++) push_wr(i, scr_c[i + 79], scr_k[i + 79]);
    for (int i = 869; i < 948; i++) push_wr(i, 8'h20, 8'h00);
    exp_col = 0;
    exp_row = 11;
  endtask

  task automatic model_cmd(input logic [7:0] ch, input logic [7:0] co);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      push_wr(exp_row * 79 + exp_col, ch, co);
      if (exp_col == 78) begin
        exp_col = 0;
        if (exp_row == 11) model_scroll();
        else exp_row++;
      end else begin
        exp_col++;
      end
    end else if (ch == 8'h0A) begin
      exp_col = 0;
      if (exp_row == 11) model_scroll();
      else exp_row++;
    end else if (ch == 8'h08) begin
      if (exp_col > 0) begin
        exp_col--;
        push_wr(exp_row * 79 + exp_col, 8'h20, 8'h00);
      end
    end else if (ch == 8'h0C) begin
      model_clear();
    end
  endtask

  // ---------------- cycle step with write scoreboard ----------------
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_we === 1'b1) begin
      we_count++;
      prev_we_cyc = last_we_cyc;
      last_we_cyc = cyc;
      last_waddr  = mem_waddr;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%0d char=%h color=%h, expected no write",
                 mem_waddr, mem_wchar, mem_wcolor);
      end else begin
        e = exp_q.pop_front();
        if (mem_waddr !== e.a || mem_wchar !== e.c || mem_wcolor !== e.k) begin
          errors++;
          $display("FAIL write_data: got addr=%0d char=%h color=%h, expected addr=%0d char=%h color=%h",
                   mem_waddr, mem_wchar, mem_wcolor, e.a, e.c, e.k);
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, n);
    end
  endtask

  // returns 1 time unit after the accepting edge
  task automatic send_cmd(input logic [7:0] ch, input logic [7:0] co);
    wait_idle();
    model_cmd(ch, co);
    cmd_valid = 1'b1;
    cmd_char  = ch;
    cmd_color = co;
    step();
    cmd_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    int w0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b busy=%b we=%b, expected 0 1 0", cmd_ready, busy, mem_we);
    end
    checks++;
    if (cursor_col !== 7'd0 || cursor_row !== 4'd0 || mem_waddr !== 10'd0 || mem_raddr !== 10'd0) begin
      errors++;
      $display("FAIL reset_regs: col=%0d row=%0d waddr=%0d raddr=%0d, expected all 0",
               cursor_col, cursor_row, mem_waddr, mem_raddr);
    end
    step();
    step();
    model_clear();
    w0 = we_count;
    rst_n = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    checks++;
    if (n != 949) begin
      errors++;
      $display("FAIL reset_ready_latency: got %0d cycles, expected 949", n);
    end
    checks++;
    if (we_count - w0 != 948) begin
      errors++;
      $display("FAIL clear_write_count: got %0d, expected 948", we_count - w0);
    end
    checks++;
    if (exp_q.size() != 0 || cursor_col !== 7'd0 || cursor_row !== 4'd0) begin
      errors++;
      $display("FAIL clear_done: pending=%0d col=%0d row=%0d, expected 0 0 0",
               exp_q.size(), cursor_col, cursor_row);
    end
  endtask

  task automatic test_back_to_back();
    int a_cyc;
    send_cmd(8'h41, 8'h02);
    a_cyc = last_we_cyc;
    send_cmd(8'h42, 8'h02);
    checks++;
    if (last_we_cyc - a_cyc != 2 || last_waddr !== 10'd1) begin
      errors++;
      $display("FAIL b2b_spacing: got gap=%0d addr=%0d, expected gap=2 addr=1",
               last_we_cyc - a_cyc, last_waddr);
    end
    wait_idle();
    checks++;
    if (cursor_col !== 7'd2 || cursor_row !== 4'd0) begin
      errors++;
      $display("FAIL b2b_cursor: got (%0d,%0d), expected (2,0)", cursor_col, cursor_row);
    end
  endtask

  task automatic test_line_wrap();
    int w0;
    for (int i = 0; i < 77; i++) send_cmd(8'h43 + 8'(i % 20), 8'(i));
    wait_idle();
    checks++;
    if (last_waddr !== 10'd78 || cursor_col !== 7'd0 || cursor_row !== 4'd1) begin
      errors++;
      $display("FAIL wrap: got addr=%0d cursor=(%0d,%0d), expected addr=78 cursor=(0,1)",
               last_waddr, cursor_col, cursor_row);
    end
    send_cmd(8'h0A, 8'h00);
    send_cmd(8'h0A, 8'h00);
    for (int i = 0; i < 5; i++) send_cmd(8'h61 + 8'(i), 8'h07);
    wait_idle();
    w0 = we_count;
    send_cmd(8'h0A, 8'h00);
    checks++;
    if (cmd_ready !== 1'b1 || cursor_col !== 7'd0 || cursor_row !== 4'd4) begin
      errors++;
      $display("FAIL newline: got ready=%b cursor=(%0d,%0d), expected ready=1 cursor=(0,4)",
               cmd_ready, cursor_col, cursor_row);
    end
    send_cmd(8'h01, 8'h00);
    checks++;
    if (cmd_ready !== 1'b1 || cursor_col !== 7'd0 || cursor_row !== 4'd4) begin
      errors++;
      $display("FAIL ignored_code: got ready=%b cursor=(%0d,%0d), expected ready=1 cursor=(0,4)",
               cmd_ready, cursor_col, cursor_row);
    end
    step();
    checks++;
    if (we_count != w0) begin
      errors++;
      $display("FAIL newline_nowrite: got %0d writes, expected 0", we_count - w0);
    end
  endtask

  task automatic test_form_feed();
    send_cmd(8'h58, 8'h0E);
    send_cmd(8'h59, 8'h0E);
    send_cmd(8'h0C, 8'h00);
    wait_idle();
    checks++;
    if (exp_q.size() != 0 || cursor_col !== 7'd0 || cursor_row !== 4'd0) begin
      errors++;
      $display("FAIL form_feed: got pending=%0d cursor=(%0d,%0d), expected 0 (0,0)",
               exp_q.size(), cursor_col, cursor_row);
    end
  endtask

  task automatic test_backspace();
    int w0;
    send_cmd(8'h0A, 8'h00);
    send_cmd(8'h0A, 8'h00);
    for (int i = 0; i < 3; i++) send_cmd(8'h30 + 8'(i), 8'h03);
    send_cmd(8'h08, 8'h00);
    wait_idle();
    checks++;
    if (last_waddr !== 10'd160 || cursor_col !== 7'd2 || cursor_row !== 4'd2) begin
      errors++;
      $display("FAIL backspace: got addr=%0d cursor=(%0d,%0d), expected addr=160 cursor=(2,2)",
               last_waddr, cursor_col, cursor_row);
    end
    send_cmd(8'h08, 8'h00);
    send_cmd(8'h08, 8'h00);
    wait_idle();
    w0 = we_count;
    send_cmd(8'h08, 8'h00);
    checks++;
    if (cmd_ready !== 1'b1 || cursor_col !== 7'd0 || cursor_row !== 4'd2) begin
      errors++;
      $display("FAIL backspace_col0: got ready=%b cursor=(%0d,%0d), expected ready=1 cursor=(0,2)",
               cmd_ready, cursor_col, cursor_row);
    end
    step();
    checks++;
    if (we_count != w0) begin
      errors++;
      $display("FAIL backspace_col0_nowrite: got %0d writes, expected 0", we_count - w0);
    end
  endtask

  task automatic test_scroll();
    int n;
    int bad;
    send_cmd(8'h0C, 8'h00);
    for (int i = 0; i < 947; i++) send_cmd(8'h21 + 8'(i % 94), 8'(i));
    wait_idle();
    checks++;
    if (cursor_col !== 7'd78 || cursor_row !== 4'd11) begin
      errors++;
      $display("FAIL fill_cursor: got (%0d,%0d), expected (78,11)", cursor_col, cursor_row);
    end
    send_cmd(8'h7E, 8'h55);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      step();
    end
    // one WRITE cycle followed by the 1817-cycle scroll
    checks++;
    if (n != 1818) begin
      errors++;
      $display("FAIL scroll_busy: got %0d busy cycles, expected 1818", n);
    end
    checks++;
    if (exp_q.size() != 0 || cursor_col !== 7'd0 || cursor_row !== 4'd11) begin
      errors++;
      $display("FAIL scroll_done: got pending=%0d cursor=(%0d,%0d), expected 0 (0,11)",
               exp_q.size(), cursor_col, cursor_row);
    end
    bad = 0;
    for (int i = 0; i < 948; i++)
      if (mchar[i] !== scr_c[i] || mcol[i] !== scr_k[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL scroll_memory: got %0d wrong cells, expected 0", bad);
    end
    send_cmd(8'h0A, 8'h00);
    checks++;
    if (busy !== 1'b1 || mem_raddr !== 10'd79) begin
      errors++;
      $display("FAIL newline_scroll_start: got busy=%b raddr=%0d, expected 1 79", busy, mem_raddr);
    end
    wait_idle();
    checks++;
    if (exp_q.size() != 0 || cursor_col !== 7'd0 || cursor_row !== 4'd11) begin
      errors++;
      $display("FAIL newline_scroll_done: got pending=%0d cursor=(%0d,%0d), expected 0 (0,11)",
               exp_q.size(), cursor_col, cursor_row);
    end
  endtask

  task automatic test_reset_mid_scroll();
    int n;
    int w0;
    send_cmd(8'h0A, 8'h00);
    for (int i = 0; i < 500; i++) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1 || mem_we !== 1'b0 || cursor_col !== 7'd0 ||
        cursor_row !== 4'd0 || mem_waddr !== 10'd0 || mem_raddr !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: got ready=%b busy=%b we=%b cursor=(%0d,%0d) waddr=%0d raddr=%0d, expected 0 1 0 (0,0) 0 0",
               cmd_ready, busy, mem_we, cursor_col, cursor_row, mem_waddr, mem_raddr);
    end
    exp_q.delete();
    step();
    step();
    model_clear();
    w0 = we_count;
    rst_n = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    checks++;
    if (n != 949 || we_count - w0 != 948) begin
      errors++;
      $display("FAIL post_reset_clear: got %0d cycles %0d writes, expected 949 948", n, we_count - w0);
    end
    checks++;
    if (exp_q.size() != 0 || cursor_col !== 7'd0 || cursor_row !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_state: got pending=%0d cursor=(%0d,%0d), expected 0 (0,0)",
               exp_q.size(), cursor_col, cursor_row);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_line_wrap();
    test_form_feed();
    test_backspace();
    test_scroll();
    test_reset_mid_scroll();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
